// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg: shared types and default constants for the RGB LED arbiter.
//   rgb_t       - packed {r,g,b} duty triple, PWM_BITS per channel
//   arb_state_t - arbiter FSM state
//   PWM_BITS, HOLD_CYCLES, BLINK_BIT - default parameter values
package rgb_led_pkg;

  localparam int unsigned PWM_BITS    = 8;
  localparam int unsigned HOLD_CYCLES = 4_800_000;  // 100 ms at 48 MHz
  localparam int unsigned BLINK_BIT   = 23;         // 2^23 cycles ~ 175 ms half-period

  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

endpackage

// File: rtl/led_pwm.sv
// led_pwm: free-running PWM counter shared by three channel comparators.
// Ports:
//   CLK_48              - system clock
//   RST_N               - asynchronous active-low reset
//   duty                - per-channel duty (rgb_t)
//   lit_r, lit_g, lit_b - channel lit this cycle (pwm_cnt < duty)
module led_pwm
  import rgb_led_pkg::*;
(
  input  logic CLK_48,
  input  logic RST_N,
  input  rgb_t duty,
  output logic lit_r,
  output logic lit_g,
  output logic lit_b
);

  logic [PWM_BITS-1:0] pwm_cnt_q;

  // Wraps naturally at 2^PWM_BITS.
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  // Strict compare: duty 0 never lights, full-scale duty misses one slot.
  always_comb begin
    lit_r = (pwm_cnt_q < duty.r);
    lit_g = (pwm_cnt_q < duty.g);
    lit_b = (pwm_cnt_q < duty.b);
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares one active-low RGB LED between NUM_REQ requesters.
// Fixed priority (index 0 highest) with a minimum ownership hold before preemption,
// per-channel PWM colour from the owner and optional blink.
// Ports:
//   CLK_48, RST_N        - clock, asynchronous active-low reset
//   REQ[NUM_REQ]         - level requests
//   REQ_COLOR            - requester i at [i*3*PWM_BITS +: 3*PWM_BITS], packed {R,G,B}
//   REQ_BLINK[NUM_REQ]   - per-requester blink enable (sampled live)
//   GRANT[NUM_REQ]       - one-hot owner, zero when idle
//   ACTIVE               - an owner is granted
//   LED_R, LED_G, LED_B  - active-low LED drive, registered
// The PWM_BITS parameter must match the width baked into rgb_led_pkg::rgb_t.
module rgb_led_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PWM_BITS    = rgb_led_pkg::PWM_BITS,
  parameter int unsigned HOLD_CYCLES = rgb_led_pkg::HOLD_CYCLES,
  parameter int unsigned BLINK_BIT   = rgb_led_pkg::BLINK_BIT
) (
  input  logic                        CLK_48,
  input  logic                        RST_N,
  input  logic [NUM_REQ-1:0]          REQ,
  input  logic [NUM_REQ*3*PWM_BITS-1:0] REQ_COLOR,
  input  logic [NUM_REQ-1:0]          REQ_BLINK,
  output logic [NUM_REQ-1:0]          GRANT,
  output logic                        ACTIVE,
  output logic                        LED_R,
  output logic                        LED_G,
  output logic                        LED_B
);

  import rgb_led_pkg::*;

  localparam int unsigned ColW  = 3 * PWM_BITS;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldReload = HoldW'(HOLD_CYCLES - 1);

  // Isolate the lowest set bit: lowest index is highest priority.
  function automatic logic [NUM_REQ-1:0] pick_lowest(input logic [NUM_REQ-1:0] req);
    return req & (~req + NUM_REQ'(1));
  endfunction

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [BLINK_BIT:0]   blink_cnt_q, blink_cnt_d;
  rgb_t                 duty_q, duty_d;
  logic [2:0]           led_q, led_d;

  logic                 owner_req;
  logic [NUM_REQ-1:0]   others;
  logic [NUM_REQ-1:0]   higher;
  logic                 lit_r, lit_g, lit_b;
  logic                 blink_on;

  always_comb begin
    owner_req = |(REQ & grant_q);
    others    = REQ & ~grant_q;
    // One-hot minus one sets exactly the bits of higher-priority requesters.
    higher    = REQ & (grant_q - NUM_REQ'(1));

    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          grant_d = pick_lowest(REQ);
          hold_d  = HoldReload;
          state_d = OWNED;
        end
      end
      OWNED: begin
        hold_d = (hold_q == '0) ? '0 : hold_q - HoldW'(1);
        if (!owner_req) begin
          if (|others) begin
            grant_d = pick_lowest(others);
            hold_d  = HoldReload;
          end else begin
            grant_d = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if ((hold_q == '0) && (|higher)) begin
          grant_d = pick_lowest(REQ);
          hold_d  = HoldReload;
        end
      end
      default: begin
        grant_d = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase

    // Duty tracks the owner that will hold the grant after this edge.
    duty_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) begin
        duty_d = REQ_COLOR[i*ColW +: ColW];
      end
    end

    // Restart on any grant change so a new blink starts lit.
    blink_cnt_d = (grant_d != grant_q) ? '0 : blink_cnt_q + (BLINK_BIT + 1)'(1);

    blink_on = !((|(REQ_BLINK & grant_q)) && blink_cnt_q[BLINK_BIT]);
    led_d    = ~({3{(state_q == OWNED) && blink_on}} & {lit_r, lit_g, lit_b});
  end

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      duty_q      <= '0;
      led_q       <= 3'b111;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      duty_q      <= duty_d;
      led_q       <= led_d;
    end
  end

  led_pwm u_led_pwm (
    .CLK_48 (CLK_48),
    .RST_N  (RST_N),
    .duty   (duty_q),
    .lit_r  (lit_r),
    .lit_g  (lit_g),
    .lit_b  (lit_b)
  );

  always_comb begin
    GRANT  = grant_q;
    ACTIVE = (state_q == OWNED);
    LED_R  = led_q[2];
    LED_G  = led_q[1];
    LED_B  = led_q[0];
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with HOLD_CYCLES=16, BLINK_BIT=4, NUM_REQ=4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_rgb_led_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned PB = 8;
  localparam int unsigned HC = 16;
  localparam int unsigned BB = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NR-1:0]        req = '0;
  logic [NR*3*PB-1:0]   req_color = '0;
  logic [NR-1:0]        req_blink = '0;
  logic [NR-1:0]        grant;
  logic                 active;
  logic                 led_r, led_g, led_b;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  // Rising edges since reset release; equals the DUT's PWM counter modulo 256.
  int unsigned edges;

  rgb_led_arbiter #(
    .NUM_REQ     (NR),
    .PWM_BITS    (PB),
    .HOLD_CYCLES (HC),
    .BLINK_BIT   (BB)
  ) dut (
    .CLK_48    (clk),
    .RST_N     (rst_n),
    .REQ       (req),
    .REQ_COLOR (req_color),
    .REQ_BLINK (req_blink),
    .GRANT     (grant),
    .ACTIVE    (active),
    .LED_R     (led_r),
    .LED_G     (led_g),
    .LED_B     (led_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_color(input int idx, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
    req_color[idx*3*PB +: 3*PB] = {r, g, b};
  endtask

  function automatic logic [2:0] leds();
    return {led_r, led_g, led_b};
  endfunction

  // Full-scale duty is dark only when the PWM counter seen by the LED register was 255.
  function automatic logic full_lit(input int unsigned e);
    return ((e - 1) % 256) != 255;
  endfunction

  initial begin
    logic on;
    #1;
    // 1: reset held, requests toggling
    for (int i = 0; i < 4; i++) begin
      req = NR'(1) << i;
      step(1);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_active", 32'(active), 32'h0);
      check("rst_leds", 32'(leds()), 32'h7);
    end
    req = '0;
    rst_n = 1'b1;
    step(2);
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_leds", 32'(leds()), 32'h7);

    // 2: red at full scale from requester 2
    set_color(2, 8'd255, 8'd0, 8'd0);
    req = 4'b0100;
    step(1);
    check("r2_grant", 32'(grant), 32'b0100);
    check("r2_active", 32'(active), 32'h1);
    check("r2_led_latency", 32'(leds()), 32'h7);
    for (int j = 0; j < 300; j++) begin
      step(1);
      check("r2_pwm", 32'(leds()), 32'({!full_lit(edges), 1'b1, 1'b1}));
    end
    req = '0;
    step(1);
    check("r2_release_grant", 32'(grant), 32'h0);
    check("r2_release_active", 32'(active), 32'h0);
    step(1);
    check("r2_release_leds", 32'(leds()), 32'h7);

    // 3: higher priority waits out the hold period
    set_color(3, 8'd10, 8'd20, 8'd30);
    set_color(0, 8'd40, 8'd50, 8'd60);
    req = 4'b1000;
    step(1);
    check("r3_grant", 32'(grant), 32'b1000);
    step(3);
    req = 4'b1001;
    for (int i = 4; i < 16; i++) begin
      step(1);
      check("r3_hold", 32'(grant), 32'b1000);
    end
    step(1);
    check("r3_preempt", 32'(grant), 32'b0001);
    req = '0;
    step(2);
    check("r3_idle", 32'(grant), 32'h0);

    // 4: blinking white from requester 1
    set_color(1, 8'd255, 8'd255, 8'd255);
    req_blink = 4'b0010;
    req = 4'b0010;
    step(1);
    check("r4_grant", 32'(grant), 32'b0010);
    for (int j = 1; j <= 56; j++) begin
      step(1);
      on = (((j - 1) / 16) % 2 == 0) && full_lit(edges);
      check("r4_blink", 32'(leds()), on ? 32'h0 : 32'h7);
    end

    // 5: owner drops while lower-priority requesters wait; blink phase restarts
    set_color(2, 8'd255, 8'd255, 8'd255);
    req_blink = 4'b0110;
    req = 4'b1110;
    step(1);
    check("r5_no_lower_preempt", 32'(grant), 32'b0010);
    req = 4'b1100;
    step(1);
    check("r5_handover", 32'(grant), 32'b0100);
    check("r5_active", 32'(active), 32'h1);
    for (int j = 1; j <= 20; j++) begin
      step(1);
      on = (((j - 1) / 16) % 2 == 0) && full_lit(edges);
      check("r5_blink_restart", 32'(leds()), on ? 32'h0 : 32'h7);
    end

    // 6: asynchronous reset while owned
    rst_n = 1'b0;
    #2;
    check("r6_async_grant", 32'(grant), 32'h0);
    check("r6_async_active", 32'(active), 32'h0);
    check("r6_async_leds", 32'(leds()), 32'h7);
    set_color(0, 8'd0, 8'd128, 8'd0);
    req_blink = '0;
    req = 4'b1101;
    step(2);
    check("r6_held_grant", 32'(grant), 32'h0);
    rst_n = 1'b1;
    step(1);
    check("r6_regrant", 32'(grant), 32'b0001);
    check("r6_active", 32'(active), 32'h1);
    check("r6_led_latency", 32'(leds()), 32'h7);
    for (int j = 0; j < 138; j++) begin
      step(1);
      check("r6_green", 32'(leds()), 32'({1'b1, !((edges - 1) < 128), 1'b1}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

- Shares the single on-board RGB LED (active-low LED_R/LED_G/LED_B) between up to NUM_REQ status requesters, clocked from CLK_48.
- Fixed-priority arbitration with a minimum ownership hold time, so a preempted indication stays visible.
- Per-channel 8-bit PWM colour and an optional blink mode.
- Sits between the system's status sources and the LED pins, replacing direct pin drive.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; index 0 is highest priority.
- PWM_BITS, 8: duty width per colour channel.
- HOLD_CYCLES, 4_800_000: minimum ownership before preemption (100 ms at 48 MHz); must be ≥ 1.
- BLINK_BIT, 23: blink counter bit giving the blink half-period; 2^23 cycles ≈ 175 ms.

Ports (one clock; reset is asynchronous and active-low):
- CLK_48  in  1  system clock, 48 MHz.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  per-requester level request.
- REQ_COLOR  in  NUM_REQ*3*PWM_BITS  requester i occupies slice [i*3*PWM_BITS +: 3*PWM_BITS], packed {R,G,B}.
- REQ_BLINK  in  NUM_REQ  per-requester blink enable.
- GRANT  out  NUM_REQ  one-hot current owner; all-zero when idle.
- ACTIVE  out  1  high while an owner is granted.
- LED_R, LED_G, LED_B  out  1 each  active-low LED drive; 1 = off.

## Operation
- State IDLE, no owner:
  - If any REQ is high, grant the lowest-index requester.
  - Load hold_cnt = HOLD_CYCLES-1 and go to OWNED.
- State OWNED:
  - hold_cnt decrements to 0 and saturates there.
  - Owner's REQ low: re-arbitrate immediately among the others and reload hold_cnt. If none is requesting, go to IDLE with GRANT=0.
  - Owner's REQ high, hold_cnt==0, and a lower-index REQ high: switch to the lowest-index requester and reload hold_cnt.
  - A higher-index (lower-priority) requester never preempts.
  - Otherwise hold the current owner.
- Colour:
  - Duty registers follow the owner's REQ_COLOR every cycle (live, registered).
  - Duty registers are zeroed in IDLE.
- PWM:
  - A free-running PWM_BITS counter pwm_cnt, shared by all three channels.
  - A channel is lit when pwm_cnt < duty. Duty 0 is always off; duty 255 is lit 255 of 256 cycles.
- Blink:
  - blink_cnt is a free-running counter of BLINK_BIT+1 bits.
  - It clears on every grant change, so a blink always begins in its lit phase.
  - If the owner's REQ_BLINK is high, LEDs are forced off while blink_cnt[BLINK_BIT]==1.
  - REQ_BLINK is sampled live.
- Output: LED_x = ~(ACTIVE & lit_x & blink_on), registered.
- Simultaneous events:
  - Owner drop and higher-priority request in the same cycle: the higher-priority requester wins, with no IDLE cycle in between.
  - A lower-index request during the hold period is ignored until hold_cnt==0. It is then granted if still high.
- Reset mid-operation: all state clears immediately (asynchronous) and LEDs go off. On RST_N release, operation starts from IDLE.

## Timing
- Reset values:
  - GRANT=0, ACTIVE=0, LED_R=LED_G=LED_B=1.
  - pwm_cnt=0, blink_cnt=0, hold_cnt=0, duties=0, state IDLE.
- REQ rises in IDLE at edge N: GRANT/ACTIVE are valid after edge N+1 and duty is loaded on the same edge.
- LEDs first reflect the new owner after edge N+2, i.e. 2 cycles of latency.
- Owner release: GRANT changes 1 cycle after REQ falls; LEDs follow 1 cycle later.
- Preemption: occurs on the first edge at which hold_cnt==0 and the higher-priority REQ is sampled high. With REQ steady, ownership lasts ≥ HOLD_CYCLES cycles.
- pwm_cnt wraps from 2^PWM_BITS-1 to 0; the PWM period is 256 cycles (187.5 kHz).
- blink_cnt wraps naturally at 2^(BLINK_BIT+1).

## Structure
- Package rgb_led_pkg holds:
  - typedef rgb_t: struct {r,g,b} of PWM_BITS each.
  - enum arb_state_t: {IDLE, OWNED}.
  - Default constants: HOLD_CYCLES, BLINK_BIT, PWM_BITS.
- One sub-module, led_pwm: owns pwm_cnt and the three comparators; inputs are rgb_t duty, outputs are lit_r/g/b.
- The priority encoder is a function in the top.

## Test plan
Overrides for all scenarios: HOLD_CYCLES=16, BLINK_BIT=4, NUM_REQ=4.
1. Hold RST_N low, toggle REQ -> GRANT=0, ACTIVE=0, LEDs=1 throughout.
2. REQ[2]=1 with colour {R=255,G=0,B=0}, no blink -> GRANT=4'b0100 after 1 cycle. LED_R low for 255 of every 256 cycles; LED_G and LED_B stay 1.
3. REQ[3] owner, REQ[0] rises 3 cycles after the grant -> GRANT stays 4'b1000 until 16 cycles after the grant, then becomes 4'b0001.
4. Owner REQ[1] with REQ_BLINK[1]=1, duty 255 on all channels -> LEDs alternate on/off with a 16-cycle half-period, starting lit after the grant.
5. REQ[1] owner drops while REQ[2] and REQ[3] are high -> GRANT becomes 4'b0100 on the next edge with no idle cycle; the blink phase restarts.
6. Assert RST_N low while owned mid-PWM -> GRANT and LEDs are off immediately. After release with REQ[0] high -> regranted 1 cycle later.
